sync_fifo_param: RTL and testbench

Parametrised single-clock synchronous FIFO. It succeeds the fixed-size FIFO with these changes:
- Depth derived from address width.
- Full/empty based on true depth.
- Programmable almost-full/almost-empty thresholds.
- Registered read with a valid strobe.
- Correct simultaneous read/write at boundaries.

It sits between producer/consumer pipeline stages and wraps one dual-port RAM sub-module.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_param_if.sv | 43 ++++
 rtl/sync_fifo_ram.sv | 43 ++++
 rtl/sync_fifo_param.sv | 119 +++++++++++
 tb/tb_sync_fifo_param.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  // Number of words addressable by an ADDR_WIDTH-bit pointer.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy counter must represent 0..DEPTH inclusive, so one extra bit.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
// Optional sticky error outputs are present when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fifo_cnt;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // Side that issues requests and consumes status.
  modport master (
    output wr, data_in, rd,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, fifo_cnt
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  // The FIFO itself.
  modport slave (
    input  wr, data_in, rd,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, fifo_cnt
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Dual-port read-first RAM: synchronous write port, registered read port.
// The read register clears on rst so the FIFO output starts at zero; the
// storage array itself is never cleared.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port: store the accepted word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: non-blocking sampling returns the pre-write word (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read, valid strobe and
// programmable almost-full/almost-empty thresholds.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);

  // Thresholds outside these ranges would make a flag stuck or meaningless.
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= DEPTH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full, empty;
  logic                  rd_acc, wr_acc;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside an accepted read; an empty FIFO never bypasses write data.
  assign rd_acc = bus.rd && !empty;
  assign wr_acc = bus.wr && (!full || rd_acc);

  // Next-state for pointers, occupancy and read strobe.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.data_in),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (bus.data_out)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.fifo_cnt     = cnt_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (cnt_q <= CW'(AE_THRESH));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error detection: a dropped write or a read of an empty FIFO.
  always_comb begin
    ovf_d = ovf_q | (bus.wr & ~wr_acc);
    unf_d = unf_q | (bus.rd & empty);
  end

  // Error flags clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_WIDTH=8, ADDR_WIDTH=3).
// A queue-based reference model predicts every output after each clock edge.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_vld;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] ovf_word;
  logic          seen_ovf_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rq);
    logic racc, wacc;
    int   n;
    rst         = r;
    bus.wr      = w;
    bus.data_in = d;
    bus.rd      = rq;
    n = mq.size();
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      racc  = rq && (n > 0);
      wacc  = w && ((n < DEPTH) || racc);
      m_ovf = m_ovf | (w && !wacc);
      m_unf = m_unf | (rq && (n == 0));
      m_vld = racc;
      if (racc) m_dout = mq.pop_front();
      if (wacc) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    n = mq.size();
    chk("fifo_cnt",     32'(bus.fifo_cnt),     32'(n));
    chk("rd_valid",     32'(bus.rd_valid),     32'(m_vld));
    chk("data_out",     32'(bus.data_out),     32'(m_dout));
    chk("full",         32'(bus.full),         32'(n == DEPTH));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
`endif
    if (bus.rd_valid && (bus.data_out == ovf_word) && seen_ovf_word) begin
      chk("rejected_word_seen", 32'(bus.data_out), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    logic w, rq;
    rst           = 1'b1;
    bus.wr        = 1'b0;
    bus.rd        = 1'b0;
    bus.data_in   = '0;
    m_dout        = '0;
    m_vld         = 1'b0;
    m_ovf         = 1'b0;
    m_unf         = 1'b0;
    ovf_word      = 8'hAA;
    seen_ovf_word = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Fill 0x10..0x17, counting up through the thresholds
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    chk("full_after_fill", 32'(bus.full), 32'd1);

    // Overflow attempt: 0xAA must be dropped and never read back
    seen_ovf_word = 1'b1;
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("cnt_after_ovf", 32'(bus.fifo_cnt), 32'd8);

    // Simultaneous read+write at full
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("sim_full_dout", 32'(bus.data_out), 32'h10);

    // Drain: 0x11..0x17 then 0x55
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("last_is_55", 32'(bus.data_out), 32'h55);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    seen_ovf_word = 1'b0;

    // Simultaneous read+write at empty: write only, then read it
    step(1'b0, 1'b1, 8'h66, 1'b1);
    chk("sim_empty_vld", 32'(bus.rd_valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("sim_empty_dout", 32'(bus.data_out), 32'h66);
    step(1'b0, 1'b0, 8'h00, 1'b1);  // underflow read
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Wrap-around: alternating write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end

    // Reset mid-operation with a read accepted in the reset cycle
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("rst_mid_vld", 32'(bus.rd_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomised traffic: write-biased, then read-biased, rare resets
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        w  = ($urandom_range(0, 99) < 70);
        rq = ($urandom_range(0, 99) < 40);
      end else begin
        w  = ($urandom_range(0, 99) < 35);
        rq = ($urandom_range(0, 99) < 70);
      end
      step(($urandom_range(0, 199) == 0), w, 8'($urandom), rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
